// File: rtl/led_shift_pkg.sv
// Shared encodings for the LED shift engine: i_mode values, FSM states
// and the mode-to-state mapping used when a new mode is loaded.
package led_shift_pkg;

  localparam logic [1:0] MODE_ROTL  = 2'b00;
  localparam logic [1:0] MODE_ROTR  = 2'b01;
  localparam logic [1:0] MODE_PP    = 2'b10;
  localparam logic [1:0] MODE_FLASH = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROT_L   = 3'd1,
    ROT_R   = 3'd2,
    PP_UP   = 3'd3,
    PP_DOWN = 3'd4,
    FLASH   = 3'd5
  } state_e;

  // Entry state for a freshly selected mode; ping-pong always starts upward.
  function automatic state_e mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_ROTL: return ROT_L;
      MODE_ROTR: return ROT_R;
      MODE_PP:   return PP_UP;
      default:   return FLASH;
    endcase
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector: turns a level that may stay high for many cycles
// into a single-cycle tick on the cycle the level is first seen high.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_tick
);

  logic en_q;

  // Registered copy of the level, updated every cycle so a held level ticks once.
  // NOTE: asynchronous reset belongs in the sensitivity list; state uses <= only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) en_q <= 1'b0;
    else     en_q <= i_level;
  end

  assign o_tick = i_level & ~en_q;

endmodule

// File: rtl/led_shift_engine.sv
// LED pattern engine: rotate-left, rotate-right, ping-pong and flash
// patterns stepped once per rising edge of i_shift_enable while i_run is high.
module led_shift_engine #(
  parameter int NB_LEDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_shift_enable,
  input  logic               i_run,
  input  logic [1:0]         i_mode,
  output logic [NB_LEDS-1:0] o_leds,
  output logic               o_dir,
  output logic               o_wrap
);

  import led_shift_pkg::*;

  localparam logic [NB_LEDS-1:0] SEED_LO  = {{(NB_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] SEED_HI  = {1'b1, {(NB_LEDS-1){1'b0}}};
  localparam logic [NB_LEDS-1:0] ALL_ONES = {NB_LEDS{1'b1}};
  localparam logic [NB_LEDS-1:0] ALL_ZERO = {NB_LEDS{1'b0}};

  state_e             state_q, state_d;
  logic [1:0]         mode_q,  mode_d;
  logic [NB_LEDS-1:0] leds_q,  leds_d;
  logic               dir_q,   dir_d;
  logic               wrap_q,  wrap_d;

  logic               tick;
  logic               leds_onehot;
  logic [NB_LEDS-1:0] rot_l, rot_r, sh_l, sh_r;

  tick_edge_detect u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_level (i_shift_enable),
    .o_tick  (tick)
  );

  assign leds_onehot = (leds_q != ALL_ZERO) && ((leds_q & (leds_q - SEED_LO)) == ALL_ZERO);
  assign rot_l = {leds_q[NB_LEDS-2:0], leds_q[NB_LEDS-1]};
  assign rot_r = {leds_q[0], leds_q[NB_LEDS-1:1]};
  assign sh_l  = {leds_q[NB_LEDS-2:0], 1'b0};
  assign sh_r  = {1'b0, leds_q[NB_LEDS-1:1]};

  // State and output registers; everything resets to the idle rotate-left seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_ROTL;
      leds_q  <= SEED_LO;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      leds_q  <= leds_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state logic: load a seed on mode change, otherwise step the pattern.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    mode_d  = mode_q;
    leds_d  = leds_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;

    if (tick && i_run) begin
      if (state_q == IDLE || i_mode != mode_q) begin
        mode_d  = i_mode;
        state_d = mode_to_state(i_mode);
        dir_d   = 1'b0;
        case (i_mode)
          MODE_ROTL, MODE_PP: leds_d = SEED_LO;
          MODE_ROTR:          leds_d = SEED_HI;
          default:            leds_d = ALL_ONES;
        endcase
      end else begin
        case (state_q)
          ROT_L: begin
            if (!leds_onehot) begin
              leds_d = SEED_LO;
            end else begin
              leds_d = rot_l;
              wrap_d = leds_q[NB_LEDS-1];
            end
          end
          ROT_R: begin
            if (!leds_onehot) begin
              leds_d = SEED_HI;
            end else begin
              leds_d = rot_r;
              wrap_d = leds_q[0];
            end
          end
          PP_UP: begin
            if (!leds_onehot || leds_q[NB_LEDS-1]) begin
              leds_d  = SEED_LO;
              state_d = PP_UP;
              dir_d   = 1'b0;
            end else begin
              leds_d = sh_l;
              if (sh_l[NB_LEDS-1]) begin
                state_d = PP_DOWN;
                dir_d   = 1'b1;
              end
            end
          end
          PP_DOWN: begin
            if (!leds_onehot || leds_q[0]) begin
              leds_d  = SEED_LO;
              state_d = PP_UP;
              dir_d   = 1'b0;
            end else begin
              leds_d = sh_r;
              if (sh_r[0]) begin
                state_d = PP_UP;
                dir_d   = 1'b0;
                wrap_d  = 1'b1;
              end
            end
          end
          FLASH: begin
            if (leds_q != ALL_ONES && leds_q != ALL_ZERO) begin
              leds_d = ALL_ONES;
            end else begin
              leds_d = ~leds_q;
              wrap_d = (leds_q == ALL_ZERO);
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  assign o_leds = leds_q;
  assign o_dir  = dir_q;
  assign o_wrap = wrap_q;

endmodule
